// File: rtl/password_entry_tx_pkg.sv
// Shared definitions for the password entry transmitter.
// Holds the entry FSM state encoding and the word geometry used by the top
// level and the testbench.
package password_entry_tx_pkg;

  localparam int PASSWORD_WIDTH = 16;
  localparam int DATA_WIDTH     = 17;
  localparam int NUM_DIGITS     = 4;
  localparam int DIGIT_WIDTH    = 4;
  localparam int COUNT_WIDTH    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/password_entry_tx_button_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter and rising-edge
// press pulse for one raw asynchronous push button.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-low reset
//   btn_i   - raw, asynchronous, active-high button
//   level_o - debounced button level
//   press_o - one-cycle pulse on the cycle after the debounced level rises
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_prev_q;
  logic          press_q;

  // The counter tracks consecutive cycles in which the synced input disagrees
  // with the accepted level; any agreeing cycle restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      cnt_q     <= '0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      db_prev_q <= db_q;
      // Registered edge detect: pulse lands one cycle after db_q goes high.
      press_q   <= db_q & ~db_prev_q;
    end
  end

  assign level_o = db_q;
  assign press_o = press_q;

endmodule

// File: rtl/password_entry_tx.sv
// Password entry transmitter: collects four hex digits from switches on
// debounced enter presses and emits {change flag, 16-bit password} with a
// one-cycle load strobe. A clear press abandons a partially entered word.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-low reset
//   Digit_In    - hex digit from switches, sampled on an accepted enter press
//   Enter_Btn   - raw enter button (active-high)
//   Clear_Btn   - raw clear button (active-high)
//   Change_Sw   - password-change request level, sampled at emission
//   Data_Out    - {change flag, password}, held between emissions
//   Data_Load   - one-cycle strobe marking Data_Out valid
//   Digit_Count - digits captured in the current word (0..4)
//   Entry_Busy  - high while a word is partially entered or being emitted
module password_entry_tx #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = password_entry_tx_pkg::NUM_DIGITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Digit_In,
  input  logic        Enter_Btn,
  input  logic        Clear_Btn,
  input  logic        Change_Sw,
  output logic [16:0] Data_Out,
  output logic        Data_Load,
  output logic [2:0]  Digit_Count,
  output logic        Entry_Busy
);

  import password_entry_tx_pkg::*;

  logic enter_ev, clear_ev;
  logic enter_lvl, clear_lvl;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (Enter_Btn),
    .level_o (enter_lvl),
    .press_o (enter_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (Clear_Btn),
    .level_o (clear_lvl),
    .press_o (clear_ev)
  );

  state_e                    state_q, state_d;
  logic [PASSWORD_WIDTH-1:0] shift_q, shift_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [DATA_WIDTH-1:0]     emit_word;

  // Change_Sw is sampled in the EMIT cycle itself, so the emitted word is
  // formed combinationally and also captured into the hold register.
  assign emit_word = {Change_Sw, shift_q};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        // Clear in IDLE has nothing to discard; it also suppresses a
        // simultaneous enter.
        if (enter_ev && !clear_ev) begin
          shift_d = {shift_q[PASSWORD_WIDTH-DIGIT_WIDTH-1:0], Digit_In};
          count_d = count_q + 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (clear_ev) begin
          shift_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (enter_ev) begin
          shift_d = {shift_q[PASSWORD_WIDTH-DIGIT_WIDTH-1:0], Digit_In};
          count_d = count_q + 1'b1;
          if (count_q == COUNT_WIDTH'(NUM_DIGITS - 1)) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        // Button events arriving here are dropped.
        data_d  = emit_word;
        shift_d = '0;
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        shift_d = '0;
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign Data_Load   = (state_q == ST_EMIT);
  assign Data_Out    = (state_q == ST_EMIT) ? emit_word : data_q;
  assign Digit_Count = count_q;
  assign Entry_Busy  = (state_q == ST_COLLECT) || (state_q == ST_EMIT);

  // Debounced levels are not needed by the entry logic.
  logic unused_lvl;
  assign unused_lvl = enter_lvl ^ clear_lvl;

endmodule

// File: tb/tb_password_entry_tx.sv
module tb_password_entry_tx;

  logic        clk;
  logic        rst;
  logic [3:0]  Digit_In;
  logic        Enter_Btn;
  logic        Clear_Btn;
  logic        Change_Sw;
  logic [16:0] Data_Out;
  logic        Data_Load;
  logic [2:0]  Digit_Count;
  logic        Entry_Busy;

  password_entry_tx #(.DEBOUNCE_CYCLES(4), .NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .Digit_In    (Digit_In),
    .Enter_Btn   (Enter_Btn),
    .Clear_Btn   (Clear_Btn),
    .Change_Sw   (Change_Sw),
    .Data_Out    (Data_Out),
    .Data_Load   (Data_Load),
    .Digit_Count (Digit_Count),
    .Entry_Busy  (Entry_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: counts strobes, keeps the word of the last one, and
  // flags back-to-back strobes.
  int          load_cnt = 0;
  int          b2b_cnt  = 0;
  logic [16:0] last_word = '0;
  logic        prev_load = 1'b0;
  always @(negedge clk) begin
    if (rst && Data_Load) begin
      load_cnt++;
      last_word = Data_Out;
      if (prev_load) b2b_cnt++;
    end
    prev_load = Data_Load;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold long enough for sync + debounce + pulse, then release long enough
  // for the released level to debounce as well.
  task automatic press_enter(input logic [3:0] d);
    Digit_In  = d;
    Enter_Btn = 1'b1;
    cycles(12);
    Enter_Btn = 1'b0;
    cycles(12);
  endtask

  task automatic press_clear();
    Clear_Btn = 1'b1;
    cycles(12);
    Clear_Btn = 1'b0;
    cycles(12);
  endtask

  int base;

  initial begin
    rst = 1'b0; Digit_In = 4'h0; Enter_Btn = 1'b0; Clear_Btn = 1'b0; Change_Sw = 1'b0;
    cycles(3);
    check("rst_data_out",  32'(Data_Out), 32'h0);
    check("rst_load",      32'(Data_Load), 32'h0);
    check("rst_count",     32'(Digit_Count), 32'h0);
    check("rst_busy",      32'(Entry_Busy), 32'h0);
    rst = 1'b1;
    cycles(3);

    // ABCD, no change request
    base = load_cnt;
    press_enter(4'hA);
    check("abcd_count1",   32'(Digit_Count), 32'd1);
    check("abcd_busy1",    32'(Entry_Busy), 32'd1);
    press_enter(4'hB);
    press_enter(4'hC);
    check("abcd_count3",   32'(Digit_Count), 32'd3);
    press_enter(4'hD);
    check("abcd_strobes",  32'(load_cnt - base), 32'd1);
    check("abcd_word",     32'(last_word), 32'h0ABCD);
    check("abcd_hold",     32'(Data_Out), 32'h0ABCD);
    check("abcd_count0",   32'(Digit_Count), 32'd0);
    check("abcd_busy0",    32'(Entry_Busy), 32'd0);

    // 1234 with change request, value must persist
    base = load_cnt;
    Change_Sw = 1'b1;
    press_enter(4'h1);
    press_enter(4'h2);
    press_enter(4'h3);
    press_enter(4'h4);
    check("chg_strobes",   32'(load_cnt - base), 32'd1);
    check("chg_word",      32'(last_word), 32'h11234);
    Change_Sw = 1'b0;
    cycles(20);
    check("chg_hold20",    32'(Data_Out), 32'h11234);

    // 5,6, clear, 7890
    base = load_cnt;
    press_enter(4'h5);
    press_enter(4'h6);
    check("clr_count2",    32'(Digit_Count), 32'd2);
    press_clear();
    check("clr_count0",    32'(Digit_Count), 32'd0);
    check("clr_busy0",     32'(Entry_Busy), 32'd0);
    check("clr_nostrobe",  32'(load_cnt - base), 32'd0);
    press_enter(4'h7);
    press_enter(4'h8);
    press_enter(4'h9);
    press_enter(4'h0);
    check("clr_strobes",   32'(load_cnt - base), 32'd1);
    check("clr_word",      32'(last_word), 32'h07890);

    // Bouncing enter followed by a long hold: one digit only
    Digit_In = 4'h3;
    Enter_Btn = 1'b1; cycles(1);
    Enter_Btn = 1'b0; cycles(1);
    Enter_Btn = 1'b1; cycles(50);
    check("bounce_count",  32'(Digit_Count), 32'd1);
    Enter_Btn = 1'b0; cycles(12);
    check("bounce_count2", 32'(Digit_Count), 32'd1);
    press_clear();
    check("bounce_clr",    32'(Digit_Count), 32'd0);

    // Enter and clear in the same cycle at count 2: clear wins
    base = load_cnt;
    press_enter(4'h2);
    press_enter(4'h4);
    Digit_In = 4'h6;
    Enter_Btn = 1'b1; Clear_Btn = 1'b1;
    cycles(12);
    Enter_Btn = 1'b0; Clear_Btn = 1'b0;
    cycles(12);
    check("both_count",    32'(Digit_Count), 32'd0);
    check("both_busy",     32'(Entry_Busy), 32'd0);
    check("both_nostrobe", 32'(load_cnt - base), 32'd0);

    // Asynchronous reset with three digits captured
    base = load_cnt;
    press_enter(4'h9);
    press_enter(4'h8);
    press_enter(4'h7);
    check("mid_count3",    32'(Digit_Count), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_count",    32'(Digit_Count), 32'd0);
    check("arst_busy",     32'(Entry_Busy), 32'd0);
    check("arst_data",     32'(Data_Out), 32'h0);
    check("arst_load",     32'(Data_Load), 32'h0);
    cycles(2);
    rst = 1'b1;
    cycles(3);
    check("arst_nostrobe", 32'(load_cnt - base), 32'd0);
    press_enter(4'hF);
    press_enter(4'h0);
    press_enter(4'h0);
    press_enter(4'h1);
    check("post_strobes",  32'(load_cnt - base), 32'd1);
    check("post_word",     32'(last_word), 32'h0F001);

    // Clear in IDLE does nothing
    press_clear();
    check("idle_clr_data", 32'(Data_Out), 32'h0F001);
    check("idle_clr_cnt",  32'(Digit_Count), 32'd0);

    // Button held through reset release yields one event after debounce
    Digit_In = 4'h7;
    Enter_Btn = 1'b1;
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(15);
    check("held_count",    32'(Digit_Count), 32'd1);
    cycles(30);
    check("held_count2",   32'(Digit_Count), 32'd1);
    Enter_Btn = 1'b0;
    cycles(12);
    press_clear();

    check("no_b2b_load",   32'(b2b_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit in case anything stalls.
  initial begin
    #500000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/password_entry_tx.md
PASSWORD_ENTRY_TX -- requirements
Module: password_entry_tx

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized cycles required to accept a button level change.
REQ-002 Parameter NUM_DIGITS, default 4, is the hex digits per word; fixed at 4 for the 16-bit password.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-low.
REQ-005 Digit_In  input  4  hex digit from switches; sampled on an accepted enter press.
REQ-006 Enter_Btn  input  1  raw, asynchronous, active-high enter button.
REQ-007 Clear_Btn  input  1  raw, asynchronous, active-high clear button.
REQ-008 Change_Sw  input  1  password-change request level; sampled at word emission.
REQ-009 Data_Out  output  17  {change flag, 16-bit password} to the access-control consumer.
REQ-010 Data_Load  output  1  one-cycle strobe marking Data_Out valid.
REQ-011 Digit_Count  output  3  digits captured in the current word, 0..4, for display.
REQ-012 Entry_Busy  output  1  high while at least one digit is captured and the word is not yet emitted.

Function
REQ-013 Each button passes a 2-flop synchronizer, then a debouncer whose level flips only after DEBOUNCE_CYCLES consecutive cycles of the opposite synced level.
REQ-014 A press event is a one-cycle pulse on the cycle after the debounced level rises; a held button yields exactly one event.
REQ-015 States: IDLE (count 0), COLLECT (count 1..3), EMIT (one cycle).
REQ-016 Enter event in IDLE or COLLECT: Shift_Reg <= {Shift_Reg[11:0], Digit_In}, count +1; first digit ends up in bits [15:12].
REQ-017 IDLE -> COLLECT on the first enter event; COLLECT -> EMIT on the enter event that makes count 4.
REQ-018 EMIT: the cycle after the 4th enter event, Data_Out = {Change_Sw sampled that cycle, Shift_Reg} and Data_Load = 1 for exactly one cycle.
REQ-019 After EMIT: Shift_Reg and count clear to 0, state IDLE; Data_Out holds its value until the next emission.
REQ-020 Clear event in COLLECT: Shift_Reg and count clear, state IDLE, no emission.
REQ-021 Clear event in IDLE: no effect.
REQ-022 Enter and clear events in the same cycle: clear wins; the digit is discarded.
REQ-023 Enter or clear events during EMIT are dropped.
REQ-024 Data_Load never asserts on consecutive cycles; minimum spacing between strobes is NUM_DIGITS enter events.
REQ-025 Digit_Count reflects the registered count; it reads 4 only during EMIT.
REQ-026 Entry_Busy = (state == COLLECT) or (state == EMIT).

Reset
REQ-027 rst low asynchronously forces state IDLE, Shift_Reg 0, count 0, Data_Out 0, Data_Load 0, Digit_Count 0, Entry_Busy 0, synchronizers and debounced levels 0, debounce counters 0.
REQ-028 Reset asserted mid-word discards all captured digits; no strobe is emitted.
REQ-029 After reset release, a button already held high produces one event once it is debounced.

Structure
REQ-030 A shared package holds the state encoding (IDLE, COLLECT, EMIT), PASSWORD_WIDTH = 16, DATA_WIDTH = 17, and NUM_DIGITS.
REQ-031 One sub-module, button_debounce, contains the synchronizer, debounce counter and rising-edge pulse; it is instantiated twice (enter, clear).

Verification
REQ-032 Enter digits A, B, C, D with Change_Sw = 0 -> one Data_Load pulse with Data_Out = 0x0ABCD; Digit_Count returns to 0.
REQ-033 Enter 1, 2, 3, 4 with Change_Sw = 1 -> Data_Out = 0x11234; Data_Out still reads 0x11234 20 cycles later.
REQ-034 Enter 5, 6, then clear, then 7, 8, 9, 0 -> exactly one strobe with Data_Out = 0x07890.
REQ-035 Enter_Btn bounces (toggles every cycle for 3 cycles), then held 50 cycles -> exactly one digit captured; Digit_Count = 1.
REQ-036 Enter and clear pressed in the same cycle while count = 2 -> count 0, no strobe.
REQ-037 rst pulsed low with count = 3 -> all outputs 0 immediately; the next 4 digits emit correctly.
